// File: rtl/stage3_execute_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled with the memory-stage hold.
// The decode/memory side drives through master; the execute stage uses slave.
interface stage3_execute_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 6
);
  logic             hold;
  logic             in_valid;
  logic [WIDTH-1:0] in_imm;
  logic [RD_W-1:0]  in_rd;
  logic [WIDTH-1:0] in_rd1;
  logic [WIDTH-1:0] in_rd2;
  logic [WIDTH-1:0] in_pc;
  logic             in_brz;
  logic             in_brn;
  logic             in_j;
  logic             in_regw;
  logic             in_wai;
  logic             in_memw;
  logic             in_memr;
  logic             in_alusrc;
  logic [2:0]       in_aluop;

  logic             zero;
  logic             neg;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_store;
  logic [RD_W-1:0]  out_rd;
  logic [WIDTH-1:0] out_pc;
  logic             out_regw;
  logic             out_wai;
  logic             out_memw;
  logic             out_memr;

  modport master (
    output hold, in_valid, in_imm, in_rd, in_rd1, in_rd2, in_pc,
           in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr,
           in_alusrc, in_aluop,
    input  zero, neg, br_taken, br_target, out_valid, out_result,
           out_store, out_rd, out_pc, out_regw, out_wai, out_memw, out_memr
  );

  modport slave (
    input  hold, in_valid, in_imm, in_rd, in_rd1, in_rd2, in_pc,
           in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr,
           in_alusrc, in_aluop,
    output zero, neg, br_taken, br_target, out_valid, out_result,
           out_store, out_rd, out_pc, out_regw, out_wai, out_memw, out_memr
  );
endinterface

// File: rtl/stage3_execute.sv
// Execute stage: ALU, condition flags, branch resolution with wrong-path squash,
// and the EX/MEM pipeline buffer.
module stage3_execute #(
  parameter int WIDTH        = 32,
  parameter int RD_W         = 6,
  parameter int SQUASH_SLOTS = 2
) (
  input logic             clk,
  input logic             rst_n,
  stage3_execute_if.slave bus
);
  localparam logic [1:0] SLOTS = 2'(SQUASH_SLOTS);

  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] result_s;
  logic             eff_s;
  logic             taken_s;
  logic             flag_en_s;

  logic [1:0]       squash_cnt_r;
  logic             zero_r;
  logic             neg_r;
  logic             br_taken_r;
  logic [WIDTH-1:0] br_target_r;
  logic             valid_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] store_r;
  logic [RD_W-1:0]  rd_r;
  logic [WIDTH-1:0] pc_r;
  logic             regw_r;
  logic             wai_r;
  logic             memw_r;
  logic             memr_r;

  // Operand B select and ALU
  always_comb begin
    op_b_s   = bus.in_alusrc ? bus.in_imm : bus.in_rd2;
    result_s = {WIDTH{1'b0}};
    case (bus.in_aluop)
      3'b000:  result_s = bus.in_rd1 + op_b_s;
      3'b001:  result_s = bus.in_rd1 - op_b_s;
      3'b010:  result_s = {WIDTH{1'b0}} - bus.in_rd1;
      3'b011:  result_s = bus.in_rd1;
      3'b100:  result_s = op_b_s;
      3'b101:  result_s = bus.in_rd1 + WIDTH'(1);
      3'b110:  result_s = bus.in_rd1 & op_b_s;
      3'b111:  result_s = bus.in_rd1 | op_b_s;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Branches use the flags as they stood before this instruction's own update
  assign eff_s     = bus.in_valid & (squash_cnt_r == 2'd0);
  assign taken_s   = eff_s & (bus.in_j | (bus.in_brz & zero_r) | (bus.in_brn & neg_r));
  assign flag_en_s = eff_s & bus.in_regw & ~bus.in_memr;

  // Condition flags, redirect request and squash window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r       <= 1'b0;
      neg_r        <= 1'b0;
      br_taken_r   <= 1'b0;
      br_target_r  <= {WIDTH{1'b0}};
      squash_cnt_r <= 2'd0;
    end else if (!bus.hold) begin
      if (flag_en_s) begin
        zero_r <= (result_s == {WIDTH{1'b0}});
        neg_r  <= result_s[WIDTH-1];
      end
      br_taken_r  <= taken_s;
      br_target_r <= bus.in_rd1;
      // Idle slots (in_valid=0) do not use up a squash slot
      if (taken_s) begin
        squash_cnt_r <= SLOTS;
      end else if ((squash_cnt_r != 2'd0) && bus.in_valid) begin
        squash_cnt_r <= squash_cnt_r - 2'd1;
      end
    end
  end

  // EX/MEM buffer; squashed slots become bubbles with all controls cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      store_r  <= {WIDTH{1'b0}};
      rd_r     <= {RD_W{1'b0}};
      pc_r     <= {WIDTH{1'b0}};
      regw_r   <= 1'b0;
      wai_r    <= 1'b0;
      memw_r   <= 1'b0;
      memr_r   <= 1'b0;
    end else if (!bus.hold) begin
      valid_r  <= eff_s;
      result_r <= result_s;
      store_r  <= bus.in_rd2;
      rd_r     <= bus.in_rd;
      pc_r     <= bus.in_pc;
      regw_r   <= eff_s & bus.in_regw;
      wai_r    <= eff_s & bus.in_wai;
      memw_r   <= eff_s & bus.in_memw;
      memr_r   <= eff_s & bus.in_memr;
    end
  end

  assign bus.zero       = zero_r;
  assign bus.neg        = neg_r;
  assign bus.br_taken   = br_taken_r;
  assign bus.br_target  = br_target_r;
  assign bus.out_valid  = valid_r;
  assign bus.out_result = result_r;
  assign bus.out_store  = store_r;
  assign bus.out_rd     = rd_r;
  assign bus.out_pc     = pc_r;
  assign bus.out_regw   = regw_r;
  assign bus.out_wai    = wai_r;
  assign bus.out_memw   = memw_r;
  assign bus.out_memr   = memr_r;
endmodule

// File: tb/tb_stage3_execute.sv
// Directed bench for stage3_execute: ALU ops, flags, branch squash, hold and async reset.
module tb_stage3_execute;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stage3_execute_if #(.WIDTH(32), .RD_W(6)) bus ();

  stage3_execute #(.WIDTH(32), .RD_W(6), .SQUASH_SLOTS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid  = 1'b0;
    bus.in_imm    = 32'd0;
    bus.in_rd     = 6'd0;
    bus.in_rd1    = 32'd0;
    bus.in_rd2    = 32'd0;
    bus.in_pc     = 32'd0;
    bus.in_brz    = 1'b0;
    bus.in_brn    = 1'b0;
    bus.in_j      = 1'b0;
    bus.in_regw   = 1'b0;
    bus.in_wai    = 1'b0;
    bus.in_memw   = 1'b0;
    bus.in_memr   = 1'b0;
    bus.in_alusrc = 1'b0;
    bus.in_aluop  = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, ".valid"},  {31'd0, bus.out_valid},  32'd0);
    check({tag, ".taken"},  {31'd0, bus.br_taken},   32'd0);
    check({tag, ".target"}, bus.br_target,           32'd0);
    check({tag, ".result"}, bus.out_result,          32'd0);
    check({tag, ".regw"},   {31'd0, bus.out_regw},   32'd0);
    check({tag, ".zero"},   {31'd0, bus.zero},       32'd0);
    check({tag, ".neg"},    {31'd0, bus.neg},        32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.hold  = 1'b0;
    clear_in();
    tick();
    tick();
    check_zeroed("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 5 + (-5) -> 0, sets zero
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd5; bus.in_imm = 32'hFFFF_FFFB;
    bus.in_alusrc = 1'b1; bus.in_regw = 1'b1; bus.in_rd = 6'd3; bus.in_pc = 32'h100;
    tick();
    check("add.result", bus.out_result, 32'd0);
    check("add.zero",   {31'd0, bus.zero},      32'd1);
    check("add.neg",    {31'd0, bus.neg},       32'd0);
    check("add.valid",  {31'd0, bus.out_valid}, 32'd1);
    check("add.regw",   {31'd0, bus.out_regw},  32'd1);
    check("add.rd",     {26'd0, bus.out_rd},    32'd3);
    check("add.pc",     bus.out_pc,             32'h100);

    // SUB 0 - 1 wraps to all ones
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd0; bus.in_rd2 = 32'd1;
    bus.in_aluop = 3'b001; bus.in_regw = 1'b1;
    tick();
    check("sub.result", bus.out_result,    32'hFFFF_FFFF);
    check("sub.neg",    {31'd0, bus.neg},  32'd1);
    check("sub.zero",   {31'd0, bus.zero}, 32'd0);

    // SUB 7 - 7 -> zero=1, neg=0
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd7; bus.in_rd2 = 32'd7;
    bus.in_aluop = 3'b001; bus.in_regw = 1'b1;
    tick();
    check("sub0.zero", {31'd0, bus.zero}, 32'd1);
    check("sub0.neg",  {31'd0, bus.neg},  32'd0);

    // BRN with neg=0: not taken, flags unchanged
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h80; bus.in_brn = 1'b1;
    tick();
    check("brn.taken", {31'd0, bus.br_taken},  32'd0);
    check("brn.valid", {31'd0, bus.out_valid}, 32'd1);
    check("brn.zero",  {31'd0, bus.zero},      32'd1);

    // BRZ with zero=1: taken to 0x40
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h40; bus.in_brz = 1'b1;
    tick();
    check("brz.taken",  {31'd0, bus.br_taken}, 32'd1);
    check("brz.target", bus.br_target,         32'h40);

    // First wrong-path instruction is squashed; its flags are not written
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd1; bus.in_rd2 = 32'd2;
    bus.in_regw = 1'b1; bus.in_memw = 1'b1;
    tick();
    check("sq1.taken", {31'd0, bus.br_taken},  32'd0);
    check("sq1.valid", {31'd0, bus.out_valid}, 32'd0);
    check("sq1.regw",  {31'd0, bus.out_regw},  32'd0);
    check("sq1.memw",  {31'd0, bus.out_memw},  32'd0);
    check("sq1.zero",  {31'd0, bus.zero},      32'd1);

    // Idle slot does not consume a squash slot
    clear_in();
    tick();
    check("idle.valid", {31'd0, bus.out_valid}, 32'd0);

    // Jump inside squash window: ignored, counter not reloaded
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h99; bus.in_j = 1'b1; bus.in_regw = 1'b1;
    tick();
    check("sqj.taken", {31'd0, bus.br_taken},  32'd0);
    check("sqj.valid", {31'd0, bus.out_valid}, 32'd0);
    check("sqj.regw",  {31'd0, bus.out_regw},  32'd0);

    // Third instruction executes
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd10; bus.in_rd2 = 32'd20; bus.in_regw = 1'b1;
    tick();
    check("post.valid",  {31'd0, bus.out_valid}, 32'd1);
    check("post.result", bus.out_result,          32'd30);
    check("post.zero",   {31'd0, bus.zero},       32'd0);

    // Jump-and-link: redirects and still writes its result
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h200; bus.in_j = 1'b1; bus.in_regw = 1'b1;
    bus.in_aluop = 3'b100; bus.in_alusrc = 1'b1; bus.in_imm = 32'h304; bus.in_pc = 32'h300;
    tick();
    check("jal.taken",  {31'd0, bus.br_taken},  32'd1);
    check("jal.target", bus.br_target,          32'h200);
    check("jal.result", bus.out_result,         32'h304);
    check("jal.valid",  {31'd0, bus.out_valid}, 32'd1);
    check("jal.regw",   {31'd0, bus.out_regw},  32'd1);

    // One squash slot used, one remaining
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h11; bus.in_regw = 1'b1;
    tick();
    check("sqa.valid",  {31'd0, bus.out_valid}, 32'd0);
    check("sqa.target", bus.br_target,          32'h11);

    // Hold for 3 cycles with a new jump presented: everything frozen
    clear_in();
    bus.hold = 1'b1;
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h500; bus.in_j = 1'b1; bus.in_regw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.valid",  {31'd0, bus.out_valid}, 32'd0);
      check("hold.taken",  {31'd0, bus.br_taken},  32'd0);
      check("hold.target", bus.br_target,          32'h11);
      check("hold.zero",   {31'd0, bus.zero},      32'd0);
    end
    bus.hold = 1'b0;

    // Remaining slot squashes this one
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd1; bus.in_rd2 = 32'd1; bus.in_regw = 1'b1;
    tick();
    check("sqb.valid", {31'd0, bus.out_valid}, 32'd0);

    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd3; bus.in_imm = 32'd4;
    bus.in_alusrc = 1'b1; bus.in_regw = 1'b1;
    tick();
    check("resume.valid",  {31'd0, bus.out_valid}, 32'd1);
    check("resume.result", bus.out_result,         32'd7);

    // Remaining ALU operations
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd1; bus.in_aluop = 3'b010; bus.in_regw = 1'b1;
    tick();
    check("neg.result", bus.out_result,   32'hFFFF_FFFF);
    check("neg.neg",    {31'd0, bus.neg}, 32'd1);

    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'hF0F0; bus.in_rd2 = 32'hFF00;
    bus.in_aluop = 3'b110; bus.in_regw = 1'b1;
    tick();
    check("and.result", bus.out_result,   32'hF000);
    check("and.store",  bus.out_store,    32'hFF00);
    check("and.neg",    {31'd0, bus.neg}, 32'd0);

    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'hF0F0; bus.in_rd2 = 32'hFF00;
    bus.in_aluop = 3'b111; bus.in_wai = 1'b1;
    tick();
    check("or.result", bus.out_result,        32'hFFF0);
    check("or.wai",    {31'd0, bus.out_wai},  32'd1);

    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'hFFFF_FFFF; bus.in_aluop = 3'b101; bus.in_regw = 1'b1;
    tick();
    check("inc.result", bus.out_result,    32'd0);
    check("inc.zero",   {31'd0, bus.zero}, 32'd1);

    // Load (memr) does not update flags
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h1234; bus.in_aluop = 3'b011;
    bus.in_regw = 1'b1; bus.in_memr = 1'b1;
    tick();
    check("ld.result", bus.out_result,        32'h1234);
    check("ld.memr",   {31'd0, bus.out_memr}, 32'd1);
    check("ld.zero",   {31'd0, bus.zero},     32'd1);

    // Jump, then asynchronous reset between edges mid-squash
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'h600; bus.in_j = 1'b1; bus.in_regw = 1'b1;
    bus.in_aluop = 3'b011;
    tick();
    check("j2.taken", {31'd0, bus.br_taken}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zeroed("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // First valid instruction after reset executes normally
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd1 = 32'd5; bus.in_imm = 32'hFFFF_FFFB;
    bus.in_alusrc = 1'b1; bus.in_regw = 1'b1;
    tick();
    check("rst_add.valid",  {31'd0, bus.out_valid}, 32'd1);
    check("rst_add.result", bus.out_result,         32'd0);
    check("rst_add.zero",   {31'd0, bus.zero},      32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
